// File: rtl/uc.sv
// uc: control unit for the single-cycle microcontroller datapath.
//
// Decodes opcode/z into the microc control lines. A small sequencer adds a
// one-cycle BOOT period after reset, a WAIT stall instruction, HALT/wake and
// a PC load enable. Decode is combinational from opcode, z and the state
// register, so register writes land on the same edge (single-cycle execution).
//
// Optional feature macro: UC_ICOUNT_EN
//   defined   -> icount is a retired-instruction counter (+1 on every edge
//                with pc_en = 1, wraps at all-ones)
//   undefined -> icount is tied to 0 and no counter flops exist
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   reset        asynchronous, active-low reset
//   opcode[5:0]  memdata[15:10] of the current instruction
//   z            ALU zero flag
//   imm          memdata[11:4], WAIT stall count
//   wake         leaves HALT (sampled only while halted)
//   s_*          datapath selects/enables, 1:1 to microc control inputs
//   s_op[2:0]    ALU operation
//   pc_en        PC register load enable
//   halted       high while in HALT
//   icount       retired-instruction count
module uc #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned IC_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             z,
  input  logic [CNT_W-1:0] imm,
  input  logic             wake,
  output logic             s_inc,
  output logic             s_io_alu,
  output logic             s_inm_alu,
  output logic             s_rel,
  output logic             s_we3,
  output logic             s_WA3,
  output logic             s_PC,
  output logic             s_inm_rd,
  output logic             s_wePC2,
  output logic             s_io_enable,
  output logic             s_io,
  output logic [2:0]       s_op,
  output logic             pc_en,
  output logic             halted,
  output logic [IC_W-1:0]  icount
);

  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_NOP  = 6'b000000;
  localparam logic [OP_W-1:0] OP_HALT = 6'b000001;
  localparam logic [OP_W-1:0] OP_WAIT = 6'b000010;
  localparam logic [OP_W-1:0] OP_IN   = 6'b000100;
  localparam logic [OP_W-1:0] OP_OUT  = 6'b000101;
  localparam logic [OP_W-1:0] OP_OUTI = 6'b000110;
  localparam logic [OP_W-1:0] OP_LI   = 6'b001000;
  localparam logic [OP_W-1:0] OP_J    = 6'b010000;
  localparam logic [OP_W-1:0] OP_JZ   = 6'b010001;
  localparam logic [OP_W-1:0] OP_JNZ  = 6'b010010;
  localparam logic [OP_W-1:0] OP_MARK = 6'b010100;
  localparam logic [OP_W-1:0] OP_BACK = 6'b010101;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  // State and stall counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_BOOT;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state, counter and control decode.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    s_inc       = 1'b1;
    s_io_alu    = 1'b0;
    s_inm_alu   = 1'b0;
    s_rel       = 1'b0;
    s_we3       = 1'b0;
    s_WA3       = 1'b0;
    s_PC        = 1'b0;
    s_inm_rd    = 1'b0;
    s_wePC2     = 1'b0;
    s_io_enable = 1'b0;
    s_io        = 1'b0;
    s_op        = 3'b000;
    pc_en       = 1'b0;
    halted      = 1'b0;

    case (state)
      ST_BOOT: begin
        state_next = ST_RUN;
      end

      ST_RUN: begin
        pc_en = 1'b1;
        if (opcode[5]) begin
          // Any opcode with the top bit set is an ALU register op.
          s_op  = opcode[2:0];
          s_we3 = 1'b1;
          s_WA3 = 1'b1;
        end else begin
          case (opcode)
            OP_NOP: begin
            end
            OP_HALT: begin
              state_next = ST_HALT;
            end
            OP_WAIT: begin
              // WAIT 0 degenerates to a NOP; otherwise hold the PC and stall.
              if (imm != '0) begin
                pc_en      = 1'b0;
                cnt_next   = imm;
                state_next = ST_WAIT;
              end
            end
            OP_IN: begin
              s_io_enable = 1'b1;
              s_io_alu    = 1'b1;
              s_we3       = 1'b1;
            end
            OP_OUT: begin
              s_io_enable = 1'b1;
              s_io        = 1'b1;
              s_inm_rd    = 1'b1;
            end
            OP_OUTI: begin
              s_io_enable = 1'b1;
              s_io        = 1'b1;
            end
            OP_LI: begin
              s_inm_alu = 1'b1;
              s_we3     = 1'b1;
              s_WA3     = 1'b1;
            end
            OP_J: begin
              s_inc = 1'b0;
            end
            OP_JZ: begin
              s_rel = z;
            end
            OP_JNZ: begin
              s_rel = ~z;
            end
            OP_MARK: begin
              s_wePC2 = 1'b1;
            end
            OP_BACK: begin
              s_PC = 1'b1;
            end
            default: begin
            end
          endcase
        end
      end

      ST_WAIT: begin
        // Last stall cycle releases the PC so the next instruction follows.
        cnt_next = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          pc_en      = 1'b1;
          state_next = ST_RUN;
        end
      end

      ST_HALT: begin
        halted = 1'b1;
        if (wake) begin
          state_next = ST_RUN;
        end
      end

      default: begin
        state_next = ST_BOOT;
      end
    endcase
  end

`ifdef UC_ICOUNT_EN
  logic [IC_W-1:0] icount_q;

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      icount_q <= '0;
    end else if (pc_en) begin
      icount_q <= icount_q + IC_W'(1);
    end
  end

  assign icount = icount_q;
`else
  assign icount = '0;
`endif

endmodule

// File: tb/tb_uc.sv
// tb_uc: self-checking bench for uc. Expected control vectors are written
// out as constants from the opcode table; a scoreboard queue carries each
// cycle's expectation from the driver to the checker.
module tb_uc;

  localparam int unsigned TB_IC_W = 4;

`ifdef UC_ICOUNT_EN
  localparam bit IC_ON = 1'b1;
`else
  localparam bit IC_ON = 1'b0;
`endif

  // Packed control view:
  // {inc, io_alu, inm_alu, rel, we3, WA3, PC, inm_rd, wePC2, io_enable, io, op[2:0], pc_en, halted}
  localparam logic [15:0] E_IDLE   = 16'h8000;
  localparam logic [15:0] E_NOP    = 16'h8002;
  localparam logic [15:0] E_HALTED = 16'h8001;
  localparam logic [15:0] E_LI     = 16'hAC02;
  localparam logic [15:0] E_IN     = 16'hC842;
  localparam logic [15:0] E_OUT    = 16'h8162;
  localparam logic [15:0] E_OUTI   = 16'h8062;
  localparam logic [15:0] E_J      = 16'h0002;
  localparam logic [15:0] E_REL    = 16'h9002;
  localparam logic [15:0] E_MARK   = 16'h8082;
  localparam logic [15:0] E_BACK   = 16'h8202;
  localparam logic [15:0] E_ALU7   = 16'h8C1E;
  localparam logic [15:0] E_ALU5   = 16'h8C16;

  typedef struct packed {
    logic [15:0]        ctl;
    logic [TB_IC_W-1:0] ic;
  } exp_t;

  logic               clk;
  logic               reset;
  logic [5:0]         opcode;
  logic               z;
  logic [7:0]         imm;
  logic               wake;
  logic               s_inc, s_io_alu, s_inm_alu, s_rel, s_we3, s_WA3;
  logic               s_PC, s_inm_rd, s_wePC2, s_io_enable, s_io;
  logic [2:0]         s_op;
  logic               pc_en, halted;
  logic [TB_IC_W-1:0] icount;

  exp_t               exp_q[$];
  logic [TB_IC_W-1:0] ic_model;
  int                 checks;
  int                 errors;

  uc #(.CNT_W(8), .IC_W(TB_IC_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .z(z), .imm(imm), .wake(wake),
    .s_inc(s_inc), .s_io_alu(s_io_alu), .s_inm_alu(s_inm_alu), .s_rel(s_rel),
    .s_we3(s_we3), .s_WA3(s_WA3), .s_PC(s_PC), .s_inm_rd(s_inm_rd),
    .s_wePC2(s_wePC2), .s_io_enable(s_io_enable), .s_io(s_io), .s_op(s_op),
    .pc_en(pc_en), .halted(halted), .icount(icount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Push this cycle's expectation, then pop and compare against the DUT.
  task automatic push_and_check(input logic [15:0] ev, input string nm);
    exp_t e;
    exp_t got_e;
    logic [15:0] got;
    e.ctl = ev;
    e.ic  = IC_ON ? ic_model : '0;
    exp_q.push_back(e);
    #1;
    got = {s_inc, s_io_alu, s_inm_alu, s_rel, s_we3, s_WA3, s_PC, s_inm_rd,
           s_wePC2, s_io_enable, s_io, s_op, pc_en, halted};
    got_e = exp_q.pop_front();
    checks++;
    if (got !== got_e.ctl) begin
      errors++;
      $display("FAIL %s ctl got %h want %h", nm, got, got_e.ctl);
    end
    checks++;
    if (icount !== got_e.ic) begin
      errors++;
      $display("FAIL %s icount got %0d want %0d", nm, icount, got_e.ic);
    end
  endtask

  // One clock cycle: called at a falling edge, returns at the next one.
  task automatic step(input logic [5:0] op, input logic zz, input logic [7:0] im,
                      input logic wk, input logic [15:0] ev, input string nm);
    opcode = op;
    z      = zz;
    imm    = im;
    wake   = wk;
    push_and_check(ev, nm);
    if (ev[1] && reset) ic_model = ic_model + TB_IC_W'(1);
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    ic_model = '0;
    step(6'b001000, 1'b0, 8'd0, 1'b0, E_IDLE, "in_reset");
    reset = 1'b1;
    step(6'b001000, 1'b0, 8'd0, 1'b0, E_IDLE, "boot");
    step(6'b001000, 1'b0, 8'd0, 1'b0, E_LI, "first_li");
  endtask

  task automatic test_decode;
    step(6'b000100, 1'b0, 8'd0, 1'b0, E_IN,   "in");
    step(6'b000101, 1'b0, 8'd0, 1'b0, E_OUT,  "out_reg");
    step(6'b000110, 1'b0, 8'd0, 1'b0, E_OUTI, "outi");
    step(6'b010000, 1'b0, 8'd0, 1'b0, E_J,    "jump");
    step(6'b010001, 1'b1, 8'd0, 1'b0, E_REL,  "jz_taken");
    step(6'b010001, 1'b0, 8'd0, 1'b0, E_NOP,  "jz_not_taken");
    step(6'b010010, 1'b0, 8'd0, 1'b0, E_REL,  "jnz_taken");
    step(6'b010010, 1'b1, 8'd0, 1'b0, E_NOP,  "jnz_not_taken");
    step(6'b010100, 1'b0, 8'd0, 1'b0, E_MARK, "mark");
    step(6'b010101, 1'b0, 8'd0, 1'b0, E_BACK, "back");
    step(6'b111111, 1'b0, 8'd0, 1'b0, E_ALU7, "alu_111111");
    step(6'b100101, 1'b1, 8'd0, 1'b0, E_ALU5, "alu_100101");
    step(6'b000011, 1'b0, 8'd0, 1'b0, E_NOP,  "unlisted_nop");
    step(6'b000000, 1'b0, 8'd0, 1'b0, E_NOP,  "nop");
  endtask

  task automatic test_wait;
    step(6'b000010, 1'b0, 8'd3, 1'b0, E_IDLE, "wait3_c0");
    step(6'b000010, 1'b0, 8'd3, 1'b0, E_IDLE, "wait3_c1");
    step(6'b000010, 1'b0, 8'd3, 1'b0, E_IDLE, "wait3_c2");
    step(6'b000010, 1'b0, 8'd3, 1'b0, E_NOP,  "wait3_c3");
    step(6'b000010, 1'b0, 8'd0, 1'b0, E_NOP,  "wait0");
    step(6'b001000, 1'b0, 8'd0, 1'b0, E_LI,   "after_wait0");
    step(6'b000010, 1'b0, 8'd1, 1'b0, E_IDLE, "wait1_c0");
    step(6'b000010, 1'b0, 8'd1, 1'b0, E_NOP,  "wait1_c1");
  endtask

  task automatic test_halt;
    step(6'b000001, 1'b0, 8'd0, 1'b1, E_NOP, "halt_instr");
    for (int i = 0; i < 5; i++) begin
      step(6'b001000, 1'b0, 8'd0, 1'b0, E_HALTED, "halted_hold");
    end
    step(6'b001000, 1'b0, 8'd0, 1'b1, E_HALTED, "halted_wake");
    step(6'b001000, 1'b0, 8'd0, 1'b0, E_LI, "after_wake");
  endtask

  task automatic test_reset_mid_wait;
    step(6'b000010, 1'b0, 8'd200, 1'b0, E_IDLE, "wait200_c0");
    step(6'b000010, 1'b0, 8'd200, 1'b0, E_IDLE, "wait200_c1");
    step(6'b000010, 1'b0, 8'd200, 1'b0, E_IDLE, "wait200_c2");
    #2;
    reset = 1'b0;
    ic_model = '0;
    push_and_check(E_IDLE, "async_reset");
    @(negedge clk);
    reset = 1'b1;
    step(6'b000000, 1'b0, 8'd0, 1'b0, E_IDLE, "reboot");
    step(6'b010100, 1'b0, 8'd0, 1'b0, E_MARK, "run_after_reboot");
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 20; i++) begin
      step(6'b000000, 1'b0, 8'd0, 1'b0, E_NOP, "nop_stream");
    end
    step(6'b111000, 1'b0, 8'd0, 1'b0, 16'h8C02, "alu_000_op");
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    ic_model = '0;
    reset    = 1'b0;
    opcode   = '0;
    z        = 1'b0;
    imm      = '0;
    wake     = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_decode();
    test_wait();
    test_halt();
    test_reset_mid_wait();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uc.md
# uc

Control unit for the single-cycle microcontroller datapath. Decodes the 6-bit `opcode` and the ALU zero flag `z` and drives every datapath select/enable line. Adds a small sequencer:
- one-cycle boot quiet period after reset;
- programmable stall instruction (WAIT);
- halt/wake;
- a PC hold enable.

Sits beside `microc`; its outputs connect 1:1 to the `microc` control inputs, plus `pc_en` to the PC register enable (PC instantiated as `registro_we`).

## Interface
Parameters:
- `CNT_W`, 8: width of the WAIT stall counter (matches `imm` width).
- `IC_W`, 16: width of the retired-instruction counter.

Ports:
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `opcode` in 6: `memdata[15:10]` of the current instruction.
- `z` in 1: ALU zero flag.
- `imm` in 8: `memdata[11:4]`, WAIT stall count.
- `wake` in 1: leaves HALT.
- `s_inc`, `s_io_alu`, `s_inm_alu`, `s_rel`, `s_we3`, `s_WA3`, `s_PC`, `s_inm_rd`, `s_wePC2`, `s_io_enable`, `s_io` out 1 each: datapath controls.
- `s_op` out 3: ALU operation.
- `pc_en` out 1: PC register load enable.
- `halted` out 1: high while in HALT.
- `icount` out `IC_W`: retired-instruction count.

## Operation
FSM states: BOOT, RUN, WAIT, HALT.

Default outputs:
- All writes/enables low: `s_we3`, `s_wePC2`, `s_io_enable`, `s_PC`, `s_rel`, `s_inm_alu`, `s_io_alu`, `s_inm_rd`, `s_WA3`, `s_io`.
- `s_op` = 0, `s_inc` = 1, `pc_en` = 0.

State behaviour:
- BOOT: defaults only. Next state RUN.
- RUN: `pc_en` = 1 unless stated, then decode as below. Every unlisted opcode is a NOP.
  - `000000` NOP: no writes.
  - `000001` HALT: `pc_en` = 1; next state HALT.
  - `000010` WAIT: if `imm` == 0, behaves as NOP. Else `pc_en` = 0, `cnt` ← `imm`, next state WAIT.
  - `000100` IN: `s_io_enable` = 1, `s_io` = 0, `s_io_alu` = 1, `s_we3` = 1, `s_WA3` = 0.
  - `000101` OUT reg: `s_io_enable` = 1, `s_io` = 1, `s_inm_rd` = 1.
  - `000110` OUTI: `s_io_enable` = 1, `s_io` = 1, `s_inm_rd` = 0.
  - `001000` LI: `s_inm_alu` = 1, `s_we3` = 1, `s_WA3` = 1.
  - `010000` J: `s_inc` = 0.
  - `010001` JZ: `s_rel` = `z`.
  - `010010` JNZ: `s_rel` = !`z`.
  - `010100` MARK: `s_wePC2` = 1, so PC2 ← PC+1.
  - `010101` BACK: `s_PC` = 1, so PC ← PC2.
  - `1xxxxx` ALU: `s_op` = `opcode[2:0]`, `s_we3` = 1, `s_WA3` = 1.
- WAIT: defaults. `cnt` decrements each cycle. When `cnt` == 1: `pc_en` = 1, next state RUN.
- HALT: defaults, `halted` = 1. `wake` = 1 → RUN next cycle.

Arithmetic: relative jumps wrap modulo 2^10 in the datapath. `cnt` is unsigned.

## Timing
- Reset asserted: state BOOT, `cnt` = 0, `icount` = 0. All control outputs and `pc_en` are 0, `halted` = 0, `s_inc` = 1.
- First instruction executes in the 2nd rising edge after reset release.
- Decode is combinational from `opcode`/`z`/state. Register writes happen on the same edge, giving single-cycle execution.
- WAIT n (n ≥ 1) occupies exactly n+1 cycles; WAIT 0 occupies 1 cycle.
- HALT instruction retires in 1 cycle. `wake` in that same cycle is ignored; `wake` is sampled only while in HALT. Exit latency is 1 cycle; the instruction after HALT executes in the cycle after `wake` is seen.
- Reset asserted mid-WAIT or in HALT: immediate return to BOOT, counters cleared.
- `icount` increments on every edge where `pc_en` = 1, and wraps from all-ones to 0.

## Configuration
- `UC_ICOUNT_EN` defined: `icount` register and increment logic compiled in.
- Undefined: `icount` tied to 0, no counter flops.
- All other behaviour is identical in both cases.

## Test plan
- Release reset with `opcode` = `001000` (LI) → first cycle all controls 0 and `pc_en` = 0; second cycle `s_inm_alu` = `s_we3` = `s_WA3` = 1, `pc_en` = 1.
- JZ with `z` = 1 then `z` = 0 → `s_rel` = 1 then 0; `s_inc` = 1 both cycles; `icount` +2.
- WAIT `imm` = 3 → `pc_en` = 0,0,0,1 over 4 cycles, no write enables high; WAIT `imm` = 0 → `pc_en` = 1 for 1 cycle.
- HALT with `wake` = 1 in the same cycle → enters HALT; `halted` = 1 held 5 cycles with `wake` = 0; `wake` pulse → `halted` = 0 next cycle; `icount` unchanged while halted.
- Reset asserted 2 cycles into WAIT 200 → outputs 0 asynchronously; after release BOOT then RUN; `icount` = 0.
- MARK then BACK → `s_wePC2` = 1 on MARK, `s_PC` = 1 on BACK; opcode `111111` → `s_op` = 3'b111, `s_we3` = 1; opcode `000011` → NOP.
